// File: rtl/lbp_pkg.sv
// lbp_pkg: shared constants, FSM state type and address helper for the LBP
// histogram block. No ports.
package lbp_pkg;

  localparam int unsigned IMG_W   = 128;
  localparam int unsigned COORD_W = 7;
  localparam int unsigned ADDR_W  = 2 * COORD_W;
  localparam int unsigned CODE_W  = 8;
  localparam int unsigned NBINS   = 256;
  localparam int unsigned BIN_W   = 14;

  localparam logic [BIN_W-1:0]   BIN_MAX = BIN_W'(16383);
  localparam logic [COORD_W-1:0] EDGE_HI = COORD_W'(IMG_W - 1);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DUMP  = 2'd1,
    DONE  = 2'd2
  } state_t;

  // True when neither row nor column touches the image border.
  function automatic logic is_interior(input logic [ADDR_W-1:0] addr);
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    row = addr[ADDR_W-1:COORD_W];
    col = addr[COORD_W-1:0];
    return (row != '0) && (row != EDGE_HI) && (col != '0) && (col != EDGE_HI);
  endfunction

endpackage

// File: rtl/lbp_bin_bank.sv
// lbp_bin_bank: 256 x 14-bit histogram register bank.
//   i_inc_en/i_inc_idx : saturating +1 on the selected bin
//   i_rd_en/i_rd_idx   : registered read, o_rd_data valid the next cycle
//   i_clr              : clear every bin at the next edge
module lbp_bin_bank
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_inc_en,
  input  logic [CODE_W-1:0] i_inc_idx,
  input  logic              i_rd_en,
  input  logic [CODE_W-1:0] i_rd_idx,
  input  logic              i_clr,
  output logic [BIN_W-1:0]  o_rd_data
);

  logic [BIN_W-1:0] r_bins [NBINS];
  logic [BIN_W-1:0] r_rd_data;

  // Bin storage: clear-all or saturating increment.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      for (int i = 0; i < int'(NBINS); i++) begin
        r_bins[i] <= '0;
      end
    end else if (i_inc_en && (r_bins[i_inc_idx] != BIN_MAX)) begin
      r_bins[i_inc_idx] <= r_bins[i_inc_idx] + BIN_W'(1);
    end
  end

  // Registered read port; holds its value when not enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_bins[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lbp_hist.sv
// lbp_hist: accumulates a 256-bin histogram of LBP codes over the interior
// of a 128x128 frame, then streams it out as 256 valid/ready beats.
//   lbp_valid/lbp_addr/lbp_data : sample strobe, pixel address, code
//   finish                      : frame complete, start the dump
//   out_valid/out_ready         : beat handshake; out_bin/out_count/out_last payload
//   hist_done                   : one-cycle pulse after the last beat
//   addr_err                    : sticky, a border address was seen
//   total                       : saturating count of counted samples
module lbp_hist
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [CODE_W-1:0] lbp_data,
  input  logic              finish,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_bin,
  output logic [BIN_W-1:0]  out_count,
  output logic              out_last,
  output logic              hist_done,
  output logic              addr_err,
  output logic [BIN_W-1:0]  total
);

  state_t r_state, w_state_nxt;

  logic              r_out_valid, w_out_valid_nxt;
  logic [CODE_W-1:0] r_out_bin,   w_out_bin_nxt;
  logic              r_out_last,  w_out_last_nxt;
  logic              r_hist_done, w_hist_done_nxt;
  logic              r_addr_err;
  logic [BIN_W-1:0]  r_total;

  logic              w_inc_en;
  logic              w_addr_bad;
  logic              w_clr;
  logic              w_rd_en;
  logic [CODE_W-1:0] w_rd_idx;
  logic              w_accept;

  assign w_accept = r_out_valid && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, bank control and next output values.
  always_comb begin
    w_state_nxt     = r_state;
    w_inc_en        = 1'b0;
    w_addr_bad      = 1'b0;
    w_clr           = 1'b0;
    w_rd_en         = 1'b0;
    w_rd_idx        = r_out_bin;
    w_out_valid_nxt = r_out_valid;
    w_out_bin_nxt   = r_out_bin;
    w_out_last_nxt  = r_out_last;
    w_hist_done_nxt = 1'b0;
    unique case (r_state)
      ACCUM: begin
        w_inc_en   = lbp_valid && is_interior(lbp_addr);
        w_addr_bad = lbp_valid && !is_interior(lbp_addr);
        if (finish) begin
          w_state_nxt    = DUMP;
          w_out_bin_nxt  = '0;
          w_out_last_nxt = 1'b0;
        end
      end
      DUMP: begin
        w_rd_en = 1'b1;
        if (!r_out_valid) begin
          // First DUMP cycle: fetch bin 0, beat becomes valid next cycle.
          w_rd_idx        = '0;
          w_out_valid_nxt = 1'b1;
          w_out_bin_nxt   = '0;
          w_out_last_nxt  = 1'b0;
        end else if (w_accept) begin
          if (r_out_last) begin
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
            w_hist_done_nxt = 1'b1;
            w_state_nxt     = DONE;
          end else begin
            // Prefetch the following bin so the next beat is ready on time.
            w_rd_idx       = r_out_bin + CODE_W'(1);
            w_out_bin_nxt  = r_out_bin + CODE_W'(1);
            w_out_last_nxt = (r_out_bin == CODE_W'(NBINS - 2));
          end
        end
      end
      DONE: begin
        w_clr       = 1'b1;
        w_state_nxt = ACCUM;
      end
      default: begin
        w_state_nxt = ACCUM;
      end
    endcase
  end

  // Output handshake, sticky error and total counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_bin   <= '0;
      r_out_last  <= 1'b0;
      r_hist_done <= 1'b0;
      r_addr_err  <= 1'b0;
      r_total     <= '0;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      r_out_bin   <= w_out_bin_nxt;
      r_out_last  <= w_out_last_nxt;
      r_hist_done <= w_hist_done_nxt;
      if (w_addr_bad) begin
        r_addr_err <= 1'b1;
      end
      if (w_clr) begin
        r_total <= '0;
      end else if (w_inc_en && (r_total != BIN_MAX)) begin
        r_total <= r_total + BIN_W'(1);
      end
    end
  end

  lbp_bin_bank u_bank (
    .clk       (clk),
    .reset     (reset),
    .i_inc_en  (w_inc_en),
    .i_inc_idx (lbp_data),
    .i_rd_en   (w_rd_en),
    .i_rd_idx  (w_rd_idx),
    .i_clr     (w_clr),
    .o_rd_data (out_count)
  );

  assign out_valid = r_out_valid;
  assign out_bin   = r_out_bin;
  assign out_last  = r_out_last;
  assign hist_done = r_hist_done;
  assign addr_err  = r_addr_err;
  assign total     = r_total;

endmodule

// File: tb/tb_lbp_hist.sv
// tb_lbp_hist: randomized scoreboard bench for lbp_hist. Expected beats are
// queued from a counting model when finish is issued; a negedge monitor pops
// and compares accepted beats, checks stall stability and hist_done timing.
module tb_lbp_hist;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        lbp_valid = 1'b0;
  logic [13:0] lbp_addr  = '0;
  logic [7:0]  lbp_data  = '0;
  logic        finish    = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  out_bin;
  logic [13:0] out_count;
  logic        out_last;
  logic        hist_done;
  logic        addr_err;
  logic [13:0] total;

  always #5 clk = ~clk;

  lbp_hist dut (
    .clk       (clk),
    .reset     (reset),
    .lbp_valid (lbp_valid),
    .lbp_addr  (lbp_addr),
    .lbp_data  (lbp_data),
    .finish    (finish),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_count (out_count),
    .out_last  (out_last),
    .hist_done (hist_done),
    .addr_err  (addr_err),
    .total     (total)
  );

  typedef struct packed {
    logic [7:0]  bin;
    logic [13:0] cnt;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Reference model: plain counters over the frame.
  int m_hist [256];
  int m_total = 0;
  int m_err   = 0;

  bit done_seen = 1'b0;
  int beats_acc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int b = 0; b < 256; b++) m_hist[b] = 0;
    m_total = 0;
  endtask

  task automatic model_apply(input logic [13:0] a, input logic [7:0] d);
    int row, col;
    row = int'(a) / 128;
    col = int'(a) % 128;
    if (row >= 1 && row <= 126 && col >= 1 && col <= 126) begin
      if (m_hist[int'(d)] < 16383) m_hist[int'(d)]++;
      if (m_total < 16383) m_total++;
    end else begin
      m_err = 1;
    end
  endtask

  task automatic send(input logic [13:0] a, input logic [7:0] d);
    lbp_valid = 1'b1;
    lbp_addr  = a;
    lbp_data  = d;
    model_apply(a, d);
    tick();
    lbp_valid = 1'b0;
  endtask

  task automatic push_expected();
    beat_t e;
    for (int b = 0; b < 256; b++) begin
      e.bin  = 8'(b);
      e.cnt  = 14'(m_hist[b]);
      e.last = (b == 255);
      exp_q.push_back(e);
    end
    model_clear();
  endtask

  // Random samples; optional border addresses, frequent same-code runs.
  task automatic rand_samples(input int n, input bit borders);
    logic [7:0]  code;
    logic [13:0] a;
    code = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) tick();
      if ($urandom_range(0, 1) == 0) code = 8'($urandom);
      if (borders && $urandom_range(0, 7) == 0)
        a = 14'($urandom_range(0, 1) * 127 * 128 + $urandom_range(0, 127));
      else
        a = 14'($urandom_range(1, 126) * 128 + $urandom_range(1, 126));
      send(a, code);
    end
  endtask

  // Issue finish (optionally with a sample), then drain the dump.
  // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic run_dump(input int rmode, input bit noise,
                          input bit with_sample, input logic [7:0] scode);
    int cyc;
    done_seen = 1'b0;
    beats_acc = 0;
    finish = 1'b1;
    if (with_sample) begin
      lbp_valid = 1'b1;
      lbp_addr  = 14'(3 * 128 + 4);
      lbp_data  = scode;
      model_apply(lbp_addr, scode);
    end
    tick();
    finish    = 1'b0;
    lbp_valid = 1'b0;
    check("total_at_dump", int'(total), m_total);
    push_expected();
    cyc = 0;
    while (!done_seen && cyc < 4000) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (noise) begin
        lbp_valid = 1'($urandom_range(0, 1));
        lbp_addr  = 14'($urandom);
        lbp_data  = 8'($urandom);
        finish    = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
    end
    lbp_valid = 1'b0;
    finish    = 1'b0;
    out_ready = 1'b0;
    check("dump_done", int'(done_seen), 1);
    check("beat_count", beats_acc, 256);
    check("queue_drained", exp_q.size(), 0);
    check("total_cleared", int'(total), 0);
    check("addr_err_after", int'(addr_err), m_err);
  endtask

  // Monitor: scoreboard pops, stall stability, hist_done timing.
  bit          prev_stall    = 1'b0;
  bit          prev_last_acc = 1'b0;
  logic [7:0]  prev_bin;
  logic [13:0] prev_cnt;
  logic        prev_last;

  always @(negedge clk) begin
    beat_t e;
    bit    acc;
    if (reset) begin
      prev_stall    = 1'b0;
      prev_last_acc = 1'b0;
    end else begin
      if (prev_last_acc || hist_done) begin
        check("hist_done", int'(hist_done), int'(prev_last_acc));
        if (prev_last_acc) check("valid_after_last", int'(out_valid), 0);
        if (hist_done) done_seen = 1'b1;
      end
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_bin", int'(out_bin), int'(prev_bin));
        check("stall_count", int'(out_count), int'(prev_cnt));
        check("stall_last", int'(out_last), int'(prev_last));
      end
      acc = out_valid && out_ready;
      if (acc) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got bin %0d, no beat expected", out_bin);
        end else begin
          e = exp_q.pop_front();
          check("beat_bin", int'(out_bin), int'(e.bin));
          check("beat_count_val", int'(out_count), int'(e.cnt));
          check("beat_last", int'(out_last), int'(e.last));
        end
        beats_acc++;
      end
      prev_last_acc = acc && out_last;
      prev_stall    = out_valid && !out_ready;
      prev_bin      = out_bin;
      prev_cnt      = out_count;
      prev_last     = out_last;
    end
  end

  initial begin
    int cyc;
    model_clear();

    // Reset state.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_bin", int'(out_bin), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_hist_done", int'(hist_done), 0);
    check("rst_addr_err", int'(addr_err), 0);
    check("rst_total", int'(total), 0);

    // Three samples at address 129, then dump.
    send(14'd129, 8'h00);
    send(14'd129, 8'h00);
    send(14'd129, 8'hFF);
    run_dump(0, 1'b0, 1'b0, 8'h00);

    // Sample in the finish cycle is counted; DUMP-time noise is ignored.
    rand_samples(40, 1'b0);
    run_dump(2, 1'b1, 1'b1, 8'h10);

    // Full interior frame, single code.
    for (int r = 1; r <= 126; r++)
      for (int c = 1; c <= 126; c++)
        send(14'(r * 128 + c), 8'h5A);
    check("full_frame_total", int'(total), m_total);
    run_dump(0, 1'b0, 1'b0, 8'h00);

    // Border addresses: not counted, sticky error through DONE.
    send(14'd200, 8'h07);
    check("addr_err_pre", int'(addr_err), m_err);
    send(14'd0, 8'h07);
    check("addr_err_first", int'(addr_err), m_err);
    send(14'd127, 8'h08);
    send(14'd16256, 8'h09);
    send(14'd16383, 8'h0A);
    check("addr_err_held", int'(addr_err), m_err);
    run_dump(0, 1'b0, 1'b0, 8'h00);

    // Random frame with 1,0,0,1 ready pattern.
    rand_samples(300, 1'b1);
    run_dump(1, 1'b0, 1'b0, 8'h00);

    // Reset during beat 100 of a dump.
    rand_samples(60, 1'b0);
    done_seen = 1'b0;
    beats_acc = 0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    push_expected();
    out_ready = 1'b1;
    cyc = 0;
    while (beats_acc < 100 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("beats_before_reset", beats_acc, 100);
    reset = 1'b1;
    out_ready = 1'b0;
    tick();
    exp_q.delete();
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_hist_done", int'(hist_done), 0);
    check("midrst_total", int'(total), 0);
    check("midrst_addr_err", int'(addr_err), 0);
    reset = 1'b0;
    model_clear();
    m_err = 0;
    repeat (5) tick();
    check("no_done_after_reset", int'(done_seen), 0);
    run_dump(0, 1'b0, 1'b0, 8'h00);
    rand_samples(200, 1'b0);
    run_dump(2, 1'b0, 1'b0, 8'h00);

    // Saturation: more than 16383 samples to one bin.
    for (int i = 0; i < 16390; i++) send(14'(5 * 128 + 9), 8'h33);
    check("sat_total", int'(total), 16383);
    run_dump(1, 1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
